// File: rtl/hssim_del_stream_if.sv
`default_nettype none
// hssim_del_stream_if: upstream beat, pipeline and AXI-Stream signals of the HSSIM del sequencer.
// master = sequencer side, slave = surrounding environment (source, pipeline, sink).
interface hssim_del_stream_if #(
    parameter int PIXELS_PER_BEAT = 16
);
    localparam int W = 8 * PIXELS_PER_BEAT;

    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_old;
    logic [W-1:0] s_avg;
    logic [W-1:0] s_new;

    logic [W-1:0] pipe_old;
    logic [W-1:0] pipe_avg;
    logic [W-1:0] pipe_new;
    logic         pipe_stall;
    logic [W-1:0] pipe_del;

    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;

    modport master (
        input  s_valid, s_old, s_avg, s_new,
        output s_ready,
        output pipe_old, pipe_avg, pipe_new, pipe_stall,
        input  pipe_del,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready
    );

    modport slave (
        output s_valid, s_old, s_avg, s_new,
        input  s_ready,
        input  pipe_old, pipe_avg, pipe_new, pipe_stall,
        output pipe_del,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready
    );
endinterface
`default_nettype wire

// File: rtl/hssim_del_stream.sv
`default_nettype none
// hssim_del_stream: feeds the HSSIM del pipeline, tracks real outputs with tags, flushes at frame end
// and buffers results into an AXI-Stream master. HSSIM_DEL_STATS_EN adds a per-frame count of 255 pixels.
module hssim_del_stream #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int PIPE_LATENCY    = 12,
    parameter int FIFO_DEPTH      = 32
) (
    input  logic                clk,
    input  logic                aresetn,
    hssim_del_stream_if.master  bus
`ifdef HSSIM_DEL_STATS_EN
    ,
    output logic [$clog2(IMAGE_DIM*IMAGE_DIM):0] frame_changed,
    output logic                                 frame_changed_valid
`endif
);
    localparam int W     = 8 * PIXELS_PER_BEAT;
    localparam int BEATS = (IMAGE_DIM * IMAGE_DIM) / PIXELS_PER_BEAT;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FL_W  = $clog2(PIPE_LATENCY + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 2;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [PIPE_LATENCY-1:0] tag_v_q, tag_l_q;
    logic [FL_W-1:0]   inflight_q;
    logic [PTR_W:0]    fifo_cnt_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [W:0]        mem_q [FIFO_DEPTH];

    logic              w_credit;
    logic              w_advance;
    logic              w_push_v;
    logic              w_push_l;
    logic              w_wr;
    logic              w_rd;
    logic              w_tvalid;
    logic [W:0]        w_head;
    logic [OCC_W-1:0]  w_occ;

    // Credit counts tags still in the pipe so every emerging del beat has a slot.
    assign w_occ    = OCC_W'(fifo_cnt_q) + OCC_W'(inflight_q);
    assign w_credit = (w_occ < OCC_W'(FIFO_DEPTH));

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        flush_cnt_d = flush_cnt_q;
        w_advance   = 1'b0;
        w_push_v    = 1'b0;
        w_push_l    = 1'b0;
        bus.s_ready = 1'b0;
        case (state_q)
            S_FILL: begin
                bus.s_ready = aresetn & w_credit;
                w_advance   = aresetn & w_credit & bus.s_valid;
                w_push_v    = 1'b1;
                w_push_l    = (in_cnt_q == CNT_W'(BEATS - 1));
                if (w_advance) begin
                    if (w_push_l) begin
                        state_d  = S_FLUSH;
                        in_cnt_d = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                w_advance = aresetn & w_credit;
                if (w_advance) begin
                    if (flush_cnt_q == FL_W'(PIPE_LATENCY - 1)) begin
                        state_d     = S_FILL;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    assign bus.pipe_stall = ~w_advance;
    assign bus.pipe_old   = (state_q == S_FILL) ? bus.s_old : '0;
    assign bus.pipe_avg   = (state_q == S_FILL) ? bus.s_avg : '0;
    assign bus.pipe_new   = (state_q == S_FILL) ? bus.s_new : '0;

    assign w_wr     = w_advance & tag_v_q[PIPE_LATENCY-1];
    assign w_tvalid = (fifo_cnt_q != '0);
    assign w_rd     = w_tvalid & bus.m_tready;
    assign w_head   = mem_q[rd_ptr_q];

    assign bus.m_tvalid = w_tvalid;
    assign bus.m_tdata  = w_tvalid ? w_head[W-1:0] : '0;
    assign bus.m_tlast  = w_tvalid & w_head[W];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_FILL;
            in_cnt_q    <= '0;
            flush_cnt_q <= '0;
            tag_v_q     <= '0;
            tag_l_q     <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (w_advance) begin
                tag_v_q <= PIPE_LATENCY'({tag_v_q, w_push_v});
                tag_l_q <= PIPE_LATENCY'({tag_l_q, w_push_l});
            end
            case ({w_advance & w_push_v, w_wr})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
            case ({w_wr, w_rd})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= {tag_l_q[PIPE_LATENCY-1], bus.pipe_del};
    end

`ifdef HSSIM_DEL_STATS_EN
    localparam int FC_W   = $clog2(IMAGE_DIM * IMAGE_DIM) + 1;
    localparam int LANE_W = $clog2(PIXELS_PER_BEAT + 1);

    logic [LANE_W-1:0] w_sat_lanes;
    logic [FC_W-1:0]   acc_q;
    logic [FC_W-1:0]   fc_q;
    logic              fc_valid_q;

    always_comb begin
        w_sat_lanes = '0;
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            if (w_head[8*i +: 8] == 8'hFF) w_sat_lanes = w_sat_lanes + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q      <= '0;
            fc_q       <= '0;
            fc_valid_q <= 1'b0;
        end else begin
            fc_valid_q <= 1'b0;
            if (w_rd) begin
                if (w_head[W]) begin
                    fc_q       <= acc_q + FC_W'(w_sat_lanes);
                    fc_valid_q <= 1'b1;
                    acc_q      <= '0;
                end else begin
                    acc_q <= acc_q + FC_W'(w_sat_lanes);
                end
            end
        end
    end

    assign frame_changed       = fc_q;
    assign frame_changed_valid = fc_valid_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_hssim_del_stream.sv
`default_nettype none
// tb_hssim_del_stream: randomized stream test of hssim_del_stream against a queue-based frame model.
module tb_hssim_del_stream;
    localparam int PPB   = 16;
    localparam int DIM   = 16;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int W     = 8 * PPB;
    localparam int BEATS = DIM * DIM / PPB;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    hssim_del_stream_if #(.PIXELS_PER_BEAT(PPB)) bus ();

`ifdef HSSIM_DEL_STATS_EN
    logic [$clog2(DIM*DIM):0] frame_changed;
    logic                     frame_changed_valid;
`endif

    hssim_del_stream #(
        .PIXELS_PER_BEAT(PPB),
        .IMAGE_DIM(DIM),
        .PIPE_LATENCY(LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .bus(bus)
`ifdef HSSIM_DEL_STATS_EN
        ,
        .frame_changed(frame_changed),
        .frame_changed_valid(frame_changed_valid)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] del_fn(input logic [W-1:0] o, input logic [W-1:0] a, input logic [W-1:0] n);
        return o ^ a ^ n;
    endfunction

    function automatic int sat_lanes(input logic [W-1:0] d);
        int n = 0;
        for (int i = 0; i < PPB; i++) if (d[8*i +: 8] == 8'hFF) n++;
        return n;
    endfunction

    // Stand-in for the HSSIM pipeline: LAT stages that move only when not stalled.
    logic [W-1:0] stage [LAT];
    always @(posedge clk) begin
        if (!bus.pipe_stall) begin
            for (int i = LAT - 1; i > 0; i--) stage[i] <= stage[i-1];
            stage[0] <= del_fn(bus.pipe_old, bus.pipe_avg, bus.pipe_new);
        end
    end
    assign bus.pipe_del = stage[LAT-1];

    int ready_mode = 0;
    initial begin
        bus.m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.m_tready = 1'b1;
                1:       bus.m_tready = 1'b0;
                default: bus.m_tready = 1'($urandom_range(1));
            endcase
        end
    end

    // Reference model: every accepted beat must come out once, in order, with tlast on frame beat BEATS-1.
    logic [W:0] exp_q [$];
    int  in_idx = 0;
    int  out_cnt = 0;
    int  gap_cnt = 0;
    bit  gap_on = 0;
    bit  gap_check_en = 0;
    int  sat_acc = 0;
    int  fc_exp = 0;
    bit  fc_due = 0;

    always @(negedge clk) begin
        logic [W:0] e;
        if (!aresetn) begin
            exp_q.delete();
            in_idx  = 0;
            out_cnt = 0;
            gap_on  = 0;
            sat_acc = 0;
            fc_due  = 0;
        end else begin
`ifdef HSSIM_DEL_STATS_EN
            check_eq("fc_valid", frame_changed_valid, fc_due);
            if (fc_due) check_eq("fc_count", frame_changed, fc_exp);
`endif
            fc_due = 0;
            if (gap_on) begin
                if (!bus.s_ready) gap_cnt++;
                else begin
                    if (gap_check_en) check_eq("flush_gap", gap_cnt, LAT);
                    gap_on = 0;
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                exp_q.push_back({in_idx == BEATS - 1, del_fn(bus.s_old, bus.s_avg, bus.s_new)});
                if (in_idx == BEATS - 1) begin
                    gap_on  = 1;
                    gap_cnt = 0;
                end
                in_idx = (in_idx + 1) % BEATS;
            end
            if (bus.m_tvalid && bus.m_tready) begin
                if (exp_q.size() == 0) check_eq("extra_beat", bus.m_tvalid, 0);
                else begin
                    e = exp_q.pop_front();
                    check_eq("tdata", bus.m_tdata, e[W-1:0]);
                    check_eq("tlast", bus.m_tlast, e[W]);
                    out_cnt++;
                    sat_acc += sat_lanes(e[W-1:0]);
                    if (e[W]) begin
                        fc_exp  = sat_acc;
                        fc_due  = 1;
                        sat_acc = 0;
                    end
                end
            end
        end
    end

    task automatic set_data(input int pat, input int idx);
        logic [W-1:0] o, a, n;
        o = '0; a = '0; n = '0;
        for (int i = 0; i < PPB; i++) begin
            case (pat)
                0: n[8*i +: 8] = 8'(idx);
                1: begin
                    o[8*i +: 8] = 8'($urandom);
                    a[8*i +: 8] = 8'($urandom);
                    n[8*i +: 8] = 8'($urandom);
                end
                default: n[8*i +: 8] = (i < 3) ? 8'hFF : 8'($urandom_range(254));
            endcase
        end
        bus.s_old = o;
        bus.s_avg = a;
        bus.s_new = n;
    endtask

    // Called and returns just after a rising edge; offers beats until n are accepted.
    task automatic send_beats(input int n, input int vpct, input int pat, input int base, output int cycles);
        int sent = 0;
        cycles = 0;
        while (sent < n && cycles < 4000) begin
            bus.s_valid = ($urandom_range(99) < vpct);
            set_data(pat, (base + sent) % BEATS);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) sent++;
            @(posedge clk); #1;
            cycles++;
        end
        bus.s_valid = 1'b0;
        if (sent < n) check_eq("send_timeout", sent, n);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check_eq("drain_done", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        bus.s_valid = 1'b1;
        bus.s_old   = '0;
        bus.s_avg   = '0;
        bus.s_new   = {PPB{8'hA5}};
        #1;
        check_eq("rst_pipe_new", bus.pipe_new, {PPB{8'hA5}});
        check_eq("rst_stall", bus.pipe_stall, 1);
        check_eq("rst_s_ready", bus.s_ready, 0);
        check_eq("rst_tvalid", bus.m_tvalid, 0);
        check_eq("rst_tdata", bus.m_tdata, 0);
        check_eq("rst_tlast", bus.m_tlast, 0);
        repeat (3) @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        aresetn = 1'b1;

        // Continuous flow, index-valued beats: no input bubbles, LAT-cycle flush gap.
        gap_check_en = 1;
        send_beats(BEATS, 100, 0, 0, cyc);
        check_eq("fill_cycles", cyc, BEATS);
        drain();
        repeat (LAT + 2) @(posedge clk);
        #1;
        gap_check_en = 0;

        // Sink blocked: exactly DEPTH beats accepted before stall, then release.
        ready_mode = 1;
        @(posedge clk); #1;
        send_beats(DEPTH, 100, 0, 0, cyc);
        bus.s_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("held_s_ready", bus.s_ready, 0);
            check_eq("held_stall", bus.pipe_stall, 1);
            @(posedge clk); #1;
        end
        check_eq("held_accepts", in_idx, DEPTH);
        check_eq("held_tvalid", bus.m_tvalid, 1);
        bus.s_valid = 1'b0;
        ready_mode = 0;
        send_beats(BEATS - DEPTH, 100, 0, DEPTH, cyc);
        drain();

        // Random source and sink over three frames.
        ready_mode = 2;
        send_beats(3 * BEATS, 50, 1, 0, cyc);
        drain();

        // Reset in the middle of the next frame.
        send_beats(BEATS + 7, 50, 1, 0, cyc);
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_tvalid", bus.m_tvalid, 0);
        check_eq("mid_rst_tdata", bus.m_tdata, 0);
        check_eq("mid_rst_tlast", bus.m_tlast, 0);
        check_eq("mid_rst_stall", bus.pipe_stall, 1);
        check_eq("mid_rst_s_ready", bus.s_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        send_beats(BEATS, 50, 1, 0, cyc);
        drain();
        check_eq("post_reset_beats", out_cnt, BEATS);

        // Three saturated lanes per beat.
        ready_mode = 0;
        send_beats(BEATS, 100, 2, 0, cyc);
        drain();
        repeat (LAT + 2) @(posedge clk);
        #1;
        check_eq("final_tvalid", bus.m_tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
